// File: rtl/adder_pipe_seg_if.sv
// adder_pipe_seg_if
//   Operand/result stream bundle for adder_pipe_seg.
//   Parameter WIDTH : operand and sum width in bits.
//   Signals:
//     in_valid/in_ready   operand beat handshake (producer -> adder)
//     a, b, cin, sub      operands, carry-in and subtract select
//     out_valid/out_ready result beat handshake (adder -> consumer)
//     sum, cout, ovf      result, carry out of MSB, signed overflow
//   Modports: master = the side that drives operands and consumes results,
//             slave  = the adder.
interface adder_pipe_seg_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/adder_pipe_seg.sv
// adder_pipe_seg
//   Carry-pipelined adder/subtractor. The WIDTH-bit add is split into SEGS
//   segments of SW = WIDTH/SEGS bits; each pipeline stage resolves one
//   segment using the carry registered by the previous stage, so the longest
//   combinational path is a single SW-bit carry chain. Latency is SEGS+1
//   clock edges, throughput one beat per cycle, with a global stall.
//   Parameters:
//     WIDTH (8..256) operand/sum width; SEGS segment count, WIDTH % SEGS == 0.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     bus (slave)           operand/result handshake bundle (adder_pipe_seg_if)
//     op_count, stall_count statistics counters
//   Build option:
//     ADDER_PIPE_SEG_STATS_EN  when defined, op_count counts accepted beats and
//     stall_count counts cycles with out_valid && !out_ready (both saturate);
//     when undefined both are tied to zero and no counters exist.
module adder_pipe_seg #(
  parameter int WIDTH = 64,
  parameter int SEGS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  adder_pipe_seg_if.slave   bus,
  output logic [31:0]       op_count,
  output logic [31:0]       stall_count
);

  localparam int SW = WIDTH / SEGS;

  // Global advance enable: the whole pipe moves only when the output slot
  // is empty or being drained.
  logic en;

  // Stage k (0..SEGS-1) registers: operands (with b already inverted for
  // subtract), the carry into segment k, the low result bits resolved so far
  // and the beat's valid bit. The final stage is the output register set.
  logic [WIDTH-1:0] a_p [SEGS];
  logic [WIDTH-1:0] b_p [SEGS];
  logic [WIDTH-1:0] r_p [SEGS];
  logic [SEGS-1:0]  c_p;
  logic [SEGS-1:0]  vld_p;

  // seg_sum[k] is the SW-bit sum of segment k-1 plus its carry-out.
  logic [SW:0]      seg_sum [1:SEGS];
  logic [WIDTH-1:0] res_full;
  logic             ovf_next;

  function automatic logic [SW:0] seg_add(input logic [SW-1:0] x,
                                          input logic [SW-1:0] y,
                                          input logic          ci);
    return {1'b0, x} + {1'b0, y} + {{SW{1'b0}}, ci};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  always_comb begin
    for (int k = 1; k <= SEGS; k++) begin
      seg_sum[k] = seg_add(a_p[k-1][(k-1)*SW +: SW],
                           b_p[k-1][(k-1)*SW +: SW],
                           c_p[k-1]);
    end
  end

  // Top segment completes the result; overflow is carry into the MSB
  // (recovered as a^b^sum at that bit) XOR carry out of the MSB.
  always_comb begin
    res_full = r_p[SEGS-1];
    res_full[WIDTH-SW +: SW] = seg_sum[SEGS][SW-1:0];
  end

  assign ovf_next = a_p[SEGS-1][WIDTH-1] ^ b_p[SEGS-1][WIDTH-1] ^
                    res_full[WIDTH-1] ^ seg_sum[SEGS][SW];

  // Datapath registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (en) begin
      // ---- stage 0: capture operands, fold subtract into b' and c0 ----
      a_p[0] <= bus.a;
      b_p[0] <= bus.sub ? ~bus.b : bus.b;
      c_p[0] <= bus.sub | bus.cin;
      r_p[0] <= '0;
      // ---- stages 1..SEGS-1: resolve segment k-1, delay the rest ----
      for (int k = 1; k < SEGS; k++) begin
        a_p[k] <= a_p[k-1];
        b_p[k] <= b_p[k-1];
        c_p[k] <= seg_sum[k][SW];
        r_p[k] <= r_p[k-1];
        r_p[k][(k-1)*SW +: SW] <= seg_sum[k][SW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p         <= '0;
      bus.out_valid <= 1'b0;
      bus.sum       <= '0;
      bus.cout      <= 1'b0;
      bus.ovf       <= 1'b0;
    end else if (en) begin
      vld_p[0] <= bus.in_valid;
      for (int k = 1; k < SEGS; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
      // ---- stage SEGS: last segment into the output registers ----
      bus.out_valid <= vld_p[SEGS-1];
      if (vld_p[SEGS-1]) begin
        bus.sum  <= res_full;
        bus.cout <= seg_sum[SEGS][SW];
        bus.ovf  <= ovf_next;
      end
    end
  end

`ifdef ADDER_PIPE_SEG_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count    <= '0;
      stall_count <= '0;
    end else begin
      if (bus.in_valid && en) begin
        op_count <= sat_inc(op_count);
      end
      if (bus.out_valid && !bus.out_ready) begin
        stall_count <= sat_inc(stall_count);
      end
    end
  end
`else
  assign op_count    = '0;
  assign stall_count = '0;
`endif

endmodule
